// File: rtl/boron_key_sequencer_dec.sv
// Backward BORON key schedule: replays round keys K[NUM_ROUNDS] down to K[0]
// from the final-round key, one key per two cycles, with a valid/ready output.

module s_box_decryption (
   input  logic [3:0] data_i,
   output logic [3:0] data_o
);
   always_comb begin
      data_o = 4'h0;
      case (data_i)
         4'h0: data_o = 4'hA;
         4'h1: data_o = 4'h3;
         4'h2: data_o = 4'h9;
         4'h3: data_o = 4'hE;
         4'h4: data_o = 4'h1;
         4'h5: data_o = 4'hD;
         4'h6: data_o = 4'hF;
         4'h7: data_o = 4'h4;
         4'h8: data_o = 4'hC;
         4'h9: data_o = 4'h5;
         4'hA: data_o = 4'h7;
         4'hB: data_o = 4'h2;
         4'hC: data_o = 4'h6;
         4'hD: data_o = 4'h8;
         4'hE: data_o = 4'h0;
         4'hF: data_o = 4'hB;
         default: data_o = 4'h0;
      endcase
   end
endmodule

// Handshake: a round key transfers on a rising edge where rk_valid and
// rk_ready are both high; rk_valid, round_key and round_idx hold until then.
module boron_key_sequencer_dec #(
   parameter int NUM_ROUNDS = 25
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [79:0] key_in,
   input  logic        flush,
   input  logic        rk_ready,
   output logic        rk_valid,
   output logic [63:0] round_key,
   output logic [4:0]  round_idx,
   output logic        busy,
   output logic        done,
   output logic [1:0]  o_dbg_state
);
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EMIT = 2'd1,
      ST_STEP = 2'd2
   } state_t;

   localparam logic [4:0] LP_FIRST = 5'(NUM_ROUNDS);

   state_t      r_state;
   logic [79:0] r_kreg;
   logic [4:0]  r_ctr;
   logic        r_rk_valid;
   logic        r_busy;
   logic        r_done;

   logic [4:0]  w_rc;
   logic [3:0]  w_sinv;
   logic [79:0] w_t;
   logic [79:0] w_inv;

   // Undo the forward round: strip the round constant of round r-1,
   // invert the S-box on the low nibble, then rotate right by 13.
   assign w_rc  = r_ctr - 5'd1;
   assign w_t   = {r_kreg[79:64], r_kreg[63:59] ^ w_rc, r_kreg[58:4], w_sinv};
   assign w_inv = {w_t[12:0], w_t[79:13]};

   s_box_decryption u_sinv (
      .data_i (r_kreg[3:0]),
      .data_o (w_sinv)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_kreg     <= 80'd0;
         r_ctr      <= 5'd0;
         r_rk_valid <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (flush) begin
            r_state    <= ST_IDLE;
            r_rk_valid <= 1'b0;
            r_busy     <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (start) begin
                     r_kreg     <= key_in;
                     r_ctr      <= LP_FIRST;
                     r_state    <= ST_EMIT;
                     r_rk_valid <= 1'b1;
                     r_busy     <= 1'b1;
                  end
               end
               ST_EMIT: begin
                  if (rk_ready) begin
                     r_rk_valid <= 1'b0;
                     if (r_ctr == 5'd0) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                     end else begin
                        r_state <= ST_STEP;
                     end
                  end
               end
               ST_STEP: begin
                  r_kreg     <= w_inv;
                  r_ctr      <= w_rc;
                  r_state    <= ST_EMIT;
                  r_rk_valid <= 1'b1;
               end
               default: begin
                  r_state    <= ST_IDLE;
                  r_rk_valid <= 1'b0;
                  r_busy     <= 1'b0;
               end
            endcase
         end
      end
   end

   assign rk_valid    = r_rk_valid;
   assign round_key   = r_kreg[63:0];
   assign round_idx   = r_ctr;
   assign busy        = r_busy;
   assign done        = r_done;
   assign o_dbg_state = r_state;
endmodule

// File: doc/boron_key_sequencer_dec.md
BORON_KEY_SEQUENCER_DEC -- requirements
Module: boron_key_sequencer_dec

Interface
REQ-001 Parameter NUM_ROUNDS, default 25, index of the first (final-round) key emitted; legal range 1..31.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  one-cycle request to load key_in and begin the backward key sequence; honoured only in IDLE.
REQ-005 key_in  input  80  final-round key K[NUM_ROUNDS], sampled on an accepted start.
REQ-006 flush  input  1  synchronous abort; returns the block to IDLE.
REQ-007 rk_ready  input  1  downstream decryption datapath ready for a round key.
REQ-008 rk_valid  output  1  round_key and round_idx are valid.
REQ-009 round_key  output  64  current round key, equal to key register bits [63:0].
REQ-010 round_idx  output  5  round number of round_key (NUM_ROUNDS down to 0).
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 done  output  1  one-cycle pulse after round key 0 is accepted.

Function
REQ-013 The block SHALL hold an 80-bit key register kreg and a 5-bit counter ctr, with FSM states IDLE, EMIT and STEP.
REQ-014 IDLE: on start=1, the block SHALL load kreg<=key_in and ctr<=NUM_ROUNDS, then enter EMIT on the next edge.
REQ-015 EMIT: rk_valid=1, round_key=kreg[63:0], round_idx=ctr; all three SHALL remain stable until the handshake (rk_valid & rk_ready).
REQ-016 On a handshake in EMIT with ctr!=0, the block SHALL enter STEP; with ctr==0 it SHALL enter IDLE and assert done for exactly that next cycle.
REQ-017 STEP: rk_valid=0 for exactly one cycle; on its closing edge the block SHALL set kreg<=inv_step(kreg,ctr) and ctr<=ctr-1, then enter EMIT.
REQ-018 inv_step(K,r) SHALL first form T={K[79:64], K[63:59]^(r-1), K[58:4], Sinv(K[3:0])}, with 5-bit r-1 arithmetic, and then rotate T right by 13 bits: {T[12:0],T[79:13]}.
REQ-019 Sinv SHALL use the team's existing 4-bit inverse BORON S-box block s_box_decryption, with data_i and data_o ports; no other S-box table is allowed.
REQ-020 Throughput: one round key per two cycles at rk_ready=1; a full sequence is NUM_ROUNDS+1 keys in 2*(NUM_ROUNDS+1) cycles from the first EMIT cycle.
REQ-021 The block SHALL ignore start while busy=1; kreg and ctr SHALL be unaffected.
REQ-022 flush=1 in any state SHALL force IDLE on the next edge with rk_valid=0 and done=0; flush SHALL take priority over start and over a handshake in the same cycle.
REQ-023 start and flush asserted together in IDLE SHALL leave the block in IDLE.
REQ-024 rk_ready held low in EMIT SHALL stall indefinitely without changing outputs; rk_ready outside EMIT is don't-care.
REQ-025 ctr SHALL never underflow: the wrap from 0 to 31 is unreachable by construction.
REQ-026 busy SHALL be 1 in EMIT and STEP, and 0 in IDLE, including the cycle in which done is high.

Reset
REQ-027 While rst=1 the block SHALL immediately (asynchronously) force IDLE, kreg=0, ctr=0, rk_valid=0, done=0 and busy=0, so round_key=0 and round_idx=0.
REQ-028 Reset deasserted mid-sequence SHALL discard the sequence; a new start is required.

Verification
REQ-029 key_in=0, rk_ready=1, pulse start -> first EMIT shows round_idx=25 and round_key=0; 26 handshakes with idx 25..0; done pulses once, 52 cycles after the first EMIT cycle.
REQ-030 Random key_in vs. a software model of forward BORON schedule (K[r+1]=fwd(K[r])) -> each emitted key matches K[idx][63:0]; K0 matches the originating master key.
REQ-031 rk_ready low for 10 cycles at idx=17 -> round_key and round_idx stay frozen and rk_valid stays 1; sequence resumes with 16 next.
REQ-032 start pulsed at idx=12 -> ignored; sequence continues 11..0 unchanged.
REQ-033 flush asserted at idx=5 together with rk_ready=1 -> IDLE next cycle, no done; a new start restarts at idx=25.
REQ-034 rst pulsed mid-STEP, asynchronously between edges -> outputs zero immediately; busy=0 after release.
